// File: rtl/ifft_pkg.sv
// Shared definitions for the IFFT-256 back end.
//   N, W, SHIFT, LOGN : frame length, sample width, scaling shift, index width
//   rd_state_t        : read-FSM state encoding
//   rev_idx(n)        : RAM address of output sample n, (N-n) mod N
package ifft_pkg;

    localparam int unsigned N     = 256;
    localparam int unsigned W     = 16;
    localparam int unsigned SHIFT = 8;
    localparam int unsigned LOGN  = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } rd_state_t;

    // N fits in LOGN+1 bits; the subtraction is done one bit wider and the
    // top bit dropped, which is the mod-N wrap (n = 0 maps to 0).
    function automatic logic [LOGN-1:0] rev_idx(input logic [LOGN-1:0] n);
        logic [LOGN:0] d;
        d = (LOGN+1)'(N) - {1'b0, n};
        return d[LOGN-1:0];
    endfunction

endpackage

// File: rtl/ifft_pp_bank.sv
// Ping-pong sample store: two N-entry banks of complex W-bit samples.
//   clk               : clock
//   wr_en/wr_bank/wr_addr/wr_real/wr_img : write port
//   rd_en/rd_bank/rd_addr                : read request
//   rd_real/rd_img    : registered read data, valid one cycle after rd_en
// Contents are not reset; stale data is never emitted because the read
// side only runs on completed frames.
import ifft_pkg::*;

module ifft_pp_bank (
    input  logic            clk,
    input  logic            wr_en,
    input  logic            wr_bank,
    input  logic [LOGN-1:0] wr_addr,
    input  logic [W-1:0]    wr_real,
    input  logic [W-1:0]    wr_img,
    input  logic            rd_en,
    input  logic            rd_bank,
    input  logic [LOGN-1:0] rd_addr,
    output logic [W-1:0]    rd_real,
    output logic [W-1:0]    rd_img
);

    logic [2*W-1:0] mem [2*N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= {wr_real, wr_img};
        end
        if (rd_en) begin
            {rd_real, rd_img} <= mem[{rd_bank, rd_addr}];
        end
    end

endmodule

// File: rtl/ifft_out_reorder.sv
// IFFT back end: index-reverses and scales by 1/N the natural-order output
// frames of a forward FFT, ping-pong buffered for stall-free streaming.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_valid          : in_real/in_img carry a valid FFT sample
//   in_real, in_img   : FFT output sample, signed W bits
//   out_valid         : y_real/y_img/out_idx valid
//   y_real, y_img     : reordered, rounded, scaled output
//   out_idx           : output sample index n
//   out_last          : high with n = N-1
import ifft_pkg::*;

module ifft_out_reorder (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [W-1:0]    in_real,
    input  logic [W-1:0]    in_img,
    output logic            out_valid,
    output logic [W-1:0]    y_real,
    output logic [W-1:0]    y_img,
    output logic [LOGN-1:0] out_idx,
    output logic            out_last
);

    localparam logic [LOGN-1:0] CNT_LAST = '1;
    localparam logic signed [W:0] RND = (W+1)'(1) << (SHIFT-1);

    // write side
    logic [LOGN-1:0] wr_cnt;
    logic            wr_bank;
    logic            frame_rdy;

    // read FSM
    rd_state_t       state, state_nxt;
    logic [LOGN-1:0] rd_cnt, rd_cnt_nxt;
    logic            rd_bank, rd_bank_nxt;
    logic            pend, pend_nxt;
    logic            rd_en;

    // read pipeline
    logic [W-1:0]    rd_real, rd_img;
    logic            rd_vld_q;
    logic [LOGN-1:0] rd_idx_q;
    logic            rd_last_q;

    // Frame-ready is the write of sample N-1 itself, so the FSM can start
    // on the same edge the last sample lands.
    assign frame_rdy = in_valid && (wr_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (in_valid) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == CNT_LAST) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    ifft_pp_bank u_bank (
        .clk     (clk),
        .wr_en   (in_valid),
        .wr_bank (wr_bank),
        .wr_addr (wr_cnt),
        .wr_real (in_real),
        .wr_img  (in_img),
        .rd_en   (rd_en),
        .rd_bank (rd_bank),
        .rd_addr (rev_idx(rd_cnt)),
        .rd_real (rd_real),
        .rd_img  (rd_img)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            pend    <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_cnt  <= rd_cnt_nxt;
            rd_bank <= rd_bank_nxt;
            pend    <= pend_nxt;
        end
    end

    // On the last read, either a latched or a same-cycle frame-ready chains
    // straight into the other bank with n restarting at 0.
    always_comb begin
        state_nxt   = state;
        rd_cnt_nxt  = rd_cnt;
        rd_bank_nxt = rd_bank;
        pend_nxt    = pend;
        rd_en       = 1'b0;
        case (state)
            IDLE: begin
                if (frame_rdy) begin
                    state_nxt   = EMIT;
                    rd_cnt_nxt  = '0;
                    rd_bank_nxt = wr_bank;
                end
            end
            EMIT: begin
                rd_en = 1'b1;
                if (rd_cnt == CNT_LAST) begin
                    if (pend || frame_rdy) begin
                        rd_cnt_nxt  = '0;
                        rd_bank_nxt = ~rd_bank;
                        pend_nxt    = 1'b0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    rd_cnt_nxt = rd_cnt + 1'b1;
                    if (frame_rdy) begin
                        pend_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_idx_q  <= '0;
            rd_last_q <= 1'b0;
        end else begin
            rd_vld_q  <= rd_en;
            rd_idx_q  <= rd_cnt;
            rd_last_q <= rd_en && (rd_cnt == CNT_LAST);
        end
    end

    // Round half up: add 2^(SHIFT-1) one bit wide, then arithmetic shift.
    logic signed [W:0] t_re, t_im, s_re, s_im;

    always_comb begin
        t_re = $signed({rd_real[W-1], rd_real}) + RND;
        t_im = $signed({rd_img[W-1], rd_img}) + RND;
        s_re = t_re >>> SHIFT;
        s_im = t_im >>> SHIFT;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            y_real    <= '0;
            y_img     <= '0;
        end else begin
            out_valid <= rd_vld_q;
            out_last  <= rd_last_q;
            if (rd_vld_q) begin
                out_idx <= rd_idx_q;
                y_real  <= s_re[W-1:0];
                y_img   <= s_im[W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_ifft_out_reorder.sv
// Self-checking bench for ifft_out_reorder: a scoreboard of expected output
// samples is filled when a frame completes and drained by a monitor.
module tb_ifft_out_reorder;
    import ifft_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic [W-1:0]    in_real = '0;
    logic [W-1:0]    in_img = '0;
    logic            out_valid;
    logic [W-1:0]    y_real;
    logic [W-1:0]    y_img;
    logic [LOGN-1:0] out_idx;
    logic            out_last;

    ifft_out_reorder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_real   (in_real),
        .in_img    (in_img),
        .out_valid (out_valid),
        .y_real    (y_real),
        .y_img     (y_img),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_done_cyc = -1000;
    int run = 0;
    int last_run = 0;

    typedef struct {
        int idx;
        int re;
        int im;
        int last;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   fr_re[N];
    int   fr_im[N];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // floor((x + N/2) / N) written with integer division only
    function automatic int rnd_scale(input int x);
        int v;
        v = x + 128;
        if (v >= 0) return v / 256;
        return -((-v + 255) / 256);
    endfunction

    function automatic int wrap16(input int x);
        logic [15:0] t;
        t = x[15:0];
        return int'($signed(t));
    endfunction

    task automatic send_frame(input int gap);
        int nn;
        exp_t e;
        nn = int'(N);
        for (int k = 0; k < nn; k++) begin
            repeat (gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_real  = W'(fr_re[k]);
            in_img   = W'(fr_im[k]);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        last_done_cyc = cyc;
        for (int n = 0; n < nn; n++) begin
            int a;
            a = (nn - n) % nn;
            e.idx  = n;
            e.re   = rnd_scale(fr_re[a]);
            e.im   = rnd_scale(fr_im[a]);
            e.last = (n == nn - 1) ? 1 : 0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, sb.size(), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        for (int k = 0; k < int'(N); k++) begin
            fr_re[k] = 0;
            fr_im[k] = 0;
        end
    endtask

    task automatic rand_frame();
        for (int k = 0; k < int'(N); k++) begin
            fr_re[k] = wrap16(int'($urandom));
            fr_im[k] = wrap16(int'($urandom));
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (run == 0) check("latency", cyc - last_done_cyc, 2);
            run++;
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("idx", int'(out_idx), mon_e.idx);
                check("y_real", int'($signed(y_real)), mon_e.re);
                check("y_img", int'($signed(y_img)), mon_e.im);
                check("last", int'(out_last), mon_e.last);
            end
        end else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        int rvals[6];

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_last", int'(out_last), 0);
        check("rst_idx", int'(out_idx), 0);
        check("rst_re", int'(y_real), 0);
        check("rst_im", int'(y_img), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // impulse
        clear_frame();
        fr_re[0] = 25600;
        send_frame(0);
        wait_drain("impulse_drain");
        check("impulse_run", last_run, 256);

        // ramp, values truncated to the W-bit input port
        for (int k = 0; k < int'(N); k++) begin
            fr_re[k] = wrap16(k * 256);
            fr_im[k] = wrap16(-k * 256);
        end
        send_frame(0);
        wait_drain("ramp_drain");

        // rounding boundaries, streamed back to back
        rvals = '{128, 127, -128, -129, 32767, -32768};
        for (int i = 0; i < 6; i++) begin
            clear_frame();
            fr_re[0] = rvals[i];
            fr_im[0] = -rvals[i] - 1;
            send_frame(0);
        end
        wait_drain("round_drain");
        check("round_run", last_run, 6 * 256);

        // back to back random frames
        rand_frame();
        send_frame(0);
        rand_frame();
        send_frame(0);
        wait_drain("b2b_drain");
        check("b2b_run", last_run, 512);

        // gapped input, 1 sample in 3 cycles
        rand_frame();
        send_frame(2);
        wait_drain("gap_drain");
        check("gap_run", last_run, 256);

        // reset in the middle of an emit
        rand_frame();
        send_frame(0);
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            @(negedge clk);
            if (out_valid && out_idx == 8'd100) found = 1;
        end
        check("reach_n100", found, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_last", int'(out_last), 0);
        rst_n = 1'b1;
        sb.delete();
        repeat (300) @(posedge clk);
        #1;
        rand_frame();
        send_frame(0);
        wait_drain("post_rst_drain");
        check("post_rst_run", last_run, 256);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
